// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag control for a
// first-word-fall-through FIFO built on a register file.
module fifo_ctrl #(
  parameter int ADDR_BITS = 3,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr,
  input  logic                 rd,
  input  logic                 clr_err,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic [ADDR_BITS-1:0] r_addr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [ADDR_BITS:0] CNT_MAX =
    (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_LVL =
    (ADDR_BITS+1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_LVL =
    (ADDR_BITS+1)'(AE_LEVEL);
  localparam logic [ADDR_BITS:0] CNT_ONE =
    (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE =
    ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] w_ptr;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [ADDR_BITS-1:0] w_ptr_n;
  logic [ADDR_BITS-1:0] r_ptr_n;
  logic [ADDR_BITS:0]   count_n;
  logic                 ovf_n;
  logic                 udf_n;
  logic                 push;
  logic                 pop;

  // Flags decode the registered count only; pointer
  // equality is ambiguous between full and empty.
  always_comb begin
    full         = (count == CNT_MAX);
    empty        = (count == '0);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
  end

  // Accept requests against the pre-edge state.
  always_comb begin
    push   = wr & ~full;
    pop    = rd & ~empty;
    wr_en  = push;
    w_addr = w_ptr;
    r_addr = r_ptr;
  end

  // Next pointers, occupancy and sticky errors;
  // a new error beats a same-cycle clear.
  always_comb begin
    w_ptr_n = w_ptr;
    r_ptr_n = r_ptr;
    count_n = count;
    ovf_n   = overflow & ~clr_err;
    udf_n   = underflow & ~clr_err;
    if (push)
      w_ptr_n = w_ptr + PTR_ONE;
    if (pop)
      r_ptr_n = r_ptr + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
    if (wr & full)
      ovf_n = 1'b1;
    if (rd & empty)
      udf_n = 1'b1;
  end

  // State register; reset drops all contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      w_ptr     <= w_ptr_n;
      r_ptr     <= r_ptr_n;
      count     <= count_n;
      overflow  <= ovf_n;
      underflow <= udf_n;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: fifo_ctrl with a behavioural register
// file, a reference model and a data scoreboard.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr, rd, clr_err;
  logic       wr_en;
  logic [2:0] w_addr, r_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  logic [7:0] wr_data;
  logic [7:0] r_data;
  logic [7:0] mem [8];

  int n_chk = 0;
  int n_fail = 0;

  int       m_cnt;
  int       m_w, m_r;
  bit       m_ovf, m_udf;
  int       m_wraps;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDR_BITS(3), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr(wr), .rd(rd), .clr_err(clr_err),
    .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr),
    .full(full), .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always_ff @(posedge clk)
    if (wr_en) mem[w_addr] <= wr_data;

  assign r_data = mem[r_addr];

  task automatic model_reset();
    m_cnt = 0; m_w = 0; m_r = 0;
    m_ovf = 0; m_udf = 0; m_wraps = 0;
    sb.delete();
  endtask

  // One clock: drive at negedge, check handshake and
  // popped data before the edge, advance the model after.
  task automatic cycle(input bit w, input bit r,
                       input bit c, input logic [7:0] d);
    bit ep, eo;
    logic [7:0] exp_d;
    @(negedge clk);
    wr = w; rd = r; clr_err = c; wr_data = d;
    #1;
    ep = w && (m_cnt != 8);
    eo = r && (m_cnt != 0);
    n_chk++;
    if (wr_en !== ep) begin
      n_fail++;
      $display("FAIL wr_en: got %b want %b", wr_en, ep);
    end
    if (eo) begin
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: pop with no data");
      end else begin
        exp_d = sb.pop_front();
        n_chk++;
        if (r_data !== exp_d) begin
          n_fail++;
          $display("FAIL r_data: got %h want %h",
                   r_data, exp_d);
        end
      end
    end
    @(posedge clk);
    #1;
    if (ep) begin
      sb.push_back(d);
      if (m_w == 7) m_wraps++;
      m_w = (m_w + 1) % 8;
      m_cnt++;
    end
    if (eo) begin
      m_r = (m_r + 1) % 8;
      m_cnt--;
    end
    if (w && !ep) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (r && !eo) m_udf = 1;
    else if (c) m_udf = 0;
    wr = 0; rd = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; wr = 0; rd = 0; clr_err = 0;
    wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    #1;
    n_chk++;
    if (count !== 4'd0 || empty !== 1'b1 ||
        full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: cnt=%0d e=%b f=%b ae=%b af=%b",
               count, empty, full, almost_empty, almost_full);
    end
    n_chk++;
    if (w_addr !== 3'd0 || r_addr !== 3'd0 ||
        wr_en !== 1'b0 || overflow !== 1'b0 ||
        underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ptrs: wa=%0d ra=%0d we=%b ov=%b un=%b",
               w_addr, r_addr, wr_en, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (w_addr !== 3'(i)) begin
        n_fail++;
        $display("FAIL fill_waddr: got %0d want %0d",
                 w_addr, i);
      end
      cycle(1, 0, 0, 8'h11 + 8'(i));
      n_chk++;
      if (count !== 4'(i + 1) ||
          almost_empty !== (i + 1 <= 2) ||
          almost_full !== (i + 1 >= 6) ||
          full !== (i + 1 == 8) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_flags: cnt=%0d want %0d ae=%b af=%b f=%b",
                 count, i + 1, almost_empty, almost_full, full);
      end
    end
    n_chk++;
    if (w_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL fill_wrap: got %0d want 0", w_addr);
    end
  endtask

  task automatic test_overflow();
    cycle(1, 0, 0, 8'h99);
    n_chk++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: cnt=%0d ov=%b want 8 1",
               count, overflow);
    end
    cycle(1, 0, 1, 8'h9A);
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    cycle(0, 0, 1, 8'h00);
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %b want 0", overflow);
    end
  endtask

  task automatic test_full_wr_rd();
    cycle(1, 1, 0, 8'hAA);
    n_chk++;
    if (count !== 4'd7 || r_addr !== 3'd1 ||
        full !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_wrrd: cnt=%0d ra=%0d f=%b ov=%b want 7 1 0 1",
               count, r_addr, full, overflow);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'h00);
    n_chk++;
    if (empty !== 1'b1 || count !== 4'd0 ||
        underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: e=%b cnt=%0d un=%b want 1 0 0",
               empty, count, underflow);
    end
    cycle(0, 1, 0, 8'h00);
    n_chk++;
    if (underflow !== 1'b1 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL udf_set: un=%b cnt=%0d want 1 0",
               underflow, count);
    end
    cycle(1, 1, 0, 8'h5A);
    n_chk++;
    if (count !== 4'd1 || underflow !== 1'b1 ||
        r_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL empty_wrrd: cnt=%0d un=%b rd=%h want 1 1 5a",
               count, underflow, r_data);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 0, 8'h60 + 8'(i));
    w0 = m_wraps;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 8'h30 + 8'(i));
      n_chk++;
      if (count !== 4'd4 || r_addr !== 3'(m_r) ||
          w_addr !== 3'(m_w)) begin
        n_fail++;
        $display("FAIL stream: cnt=%0d ra=%0d wa=%0d want 4 %0d %0d",
                 count, r_addr, w_addr, m_r, m_w);
      end
    end
    n_chk++;
    if (m_wraps - w0 < 2) begin
      n_fail++;
      $display("FAIL stream_wraps: got %0d want 2",
               m_wraps - w0);
    end
    @(negedge clk);
    wr = 1; rd = 1; wr_data = 8'hEE;
    @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    n_chk++;
    if (count !== 4'd0 || empty !== 1'b1 ||
        full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || w_addr !== 3'd0 ||
        r_addr !== 3'd0 || overflow !== 1'b0 ||
        underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%0d e=%b wa=%0d ra=%0d ov=%b un=%b",
               count, empty, w_addr, r_addr, overflow, underflow);
    end
    wr = 0; rd = 0;
    model_reset();
    @(negedge clk);
    reset_n = 1;
    cycle(1, 0, 0, 8'h77);
    cycle(0, 1, 0, 8'h00);
    n_chk++;
    if (count !== 4'd0 || r_addr !== 3'd1 ||
        empty !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: cnt=%0d ra=%0d e=%b want 0 1 1",
               count, r_addr, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_wr_rd();
    test_underflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer/flag controller that turns an 8-entry (default) register file into a first-word-fall-through FIFO.
- Sits directly upstream of the register file and drives its write enable, write address and read address. The data path (wr_data in, r_data out) connects straight to the register file.
- Because the register file reads combinationally, its r_data always shows the oldest entry when the FIFO is not empty.
- Adds occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.

Parameters:
- ADDR_BITS, 3, register file address width; FIFO depth DEPTH = 2**ADDR_BITS.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr  input  1  push request from producer.
- rd  input  1  pop request from consumer.
- clr_err  input  1  synchronous clear of the overflow and underflow flags.
- wr_en  output  1  register file write enable.
- w_addr  output  ADDR_BITS  register file write address (tail pointer).
- r_addr  output  ADDR_BITS  register file read address (head pointer).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a wr was seen while full.
- underflow  output  1  sticky: a rd was seen while empty.

Behaviour:
- Reset (reset_n low, asynchronous):
  - w_ptr = 0, r_ptr = 0, count = 0, overflow = 0, underflow = 0.
  - Flag outputs therefore read: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (with default levels).
  - Reset deasserts into normal operation on the next edge; a reset in mid-operation drops all contents.
- Acceptance, evaluated against the state before the edge:
  - Push accepted: push = wr & ~full.
  - Pop accepted: pop = rd & ~empty.
- wr_en = push (combinational). The register file captures wr_data at w_addr on the same edge.
- Pointer and count updates:
  - On push, w_ptr increments modulo DEPTH (natural wrap from DEPTH-1 to 0).
  - On pop, r_ptr increments modulo DEPTH.
  - count: push only → +1; pop only → -1; both or neither → unchanged.
- Simultaneous wr and rd:
  - Full: only the pop is accepted and full deasserts next cycle. The write is dropped and overflow sets.
  - Empty: only the push is accepted. The read is rejected and underflow sets; the written word appears on r_data the next cycle.
  - Otherwise both are accepted, pointers both advance and count is unchanged.
- Read data / latency:
  - r_addr = r_ptr (registered), so r_data is valid combinationally whenever empty = 0.
  - Write-to-visible latency on an empty FIFO is 1 cycle.
- Flags:
  - All flags are combinational decodes of the registered count, so they update in the cycle after the accepted operation.
  - Full and empty are derived only from count, never from pointer equality.
- Error flags:
  - overflow sets on wr & full; underflow sets on rd & empty.
  - Both flags hold until clr_err.
  - If clr_err is high in the same cycle as a new error event, the set wins.
- The state is fully synchronous apart from reset; there is no FSM beyond the pointers and the counter.

Test Plan (ADDR_BITS=3, AF_LEVEL=6, AE_LEVEL=2):
- Reset release → count=0, empty=1, full=0, almost_empty=1, w_addr=r_addr=0, wr_en=0.
- Push 8 words (0x11..0x18) back-to-back → wr_en high 8 cycles, w_addr 0..7 then wraps to 0.
  - almost_empty clears at count=3; almost_full sets at count=6; full=1 after the 8th push.
- While full, assert wr alone → wr_en=0, count stays 8, overflow=1.
  - Then pulse clr_err → overflow=0.
- While full, assert wr and rd together → only the pop happens: count=7, r_addr=1, full=0, wr_en=0, overflow=1.
- Drain to empty, then one more rd → underflow=1, count=0.
  - Then wr+rd together on empty → count=1, next cycle r_data shows the new word, underflow still 1.
- Steady wr+rd at count=4 for 20 cycles → count constant at 4, both pointers wrap past 7 twice, data order preserved.
  - Assert reset_n low mid-stream → all outputs return to reset values immediately (asynchronously).
